// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory, fills the IF/ID register,
// and absorbs decode stalls and control-flow redirects without aborting in-flight reads.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        imem_read,
  output logic [15:0] imem_address,
  output logic        if_id_valid,
  output logic [15:0] if_id_ir,
  output logic [15:0] if_id_pc,
  output logic [3:0]  opcode,
  output logic        useimm5,
  output logic        useJSR,
  output logic        shf_D
);

  localparam int unsigned W = 16;
  localparam logic [W-1:0] PC_MASK = 16'hFFFE;
  localparam logic [W-1:0] NOP = 16'h0000;

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t         state, state_n;
  logic [W-1:0]   pc, pc_n, pc_inc;
  logic [W-1:0]   pending_pc, pending_pc_n;
  logic [W-1:0]   buf_ir, buf_ir_n, buf_pc, buf_pc_n;
  logic           valid_n;
  logic [W-1:0]   ir_n, ipc_n;

  assign pc_inc = W'(pc + W'(2));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC & PC_MASK;
      pending_pc  <= '0;
      buf_ir      <= '0;
      buf_pc      <= '0;
      if_id_valid <= 1'b0;
      if_id_ir    <= NOP;
      if_id_pc    <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n & PC_MASK;
      pending_pc  <= pending_pc_n;
      buf_ir      <= buf_ir_n;
      buf_pc      <= buf_pc_n;
      if_id_valid <= valid_n;
      if_id_ir    <= ir_n;
      if_id_pc    <= ipc_n;
    end
  end

  // Next-state and IF/ID update; redirect outranks stall and any response
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pending_pc_n = pending_pc;
    buf_ir_n     = buf_ir;
    buf_pc_n     = buf_pc;
    valid_n      = if_id_valid;
    ir_n         = if_id_ir;
    ipc_n        = if_id_pc;

    // Bubble when decode advances and nothing new arrives
    if (!stall) begin
      valid_n = 1'b0;
      ir_n    = NOP;
    end

    unique case (state)
      FETCH: begin
        if (redirect) begin
          if (imem_resp) begin
            pc_n = redirect_pc;
          end else begin
            pending_pc_n = redirect_pc;
            state_n      = DRAIN;
          end
        end else if (imem_resp) begin
          pc_n = pc_inc;
          if (!stall || !if_id_valid) begin
            valid_n = 1'b1;
            ir_n    = imem_rdata;
            ipc_n   = pc_inc;
          end else begin
            buf_ir_n = imem_rdata;
            buf_pc_n = pc_inc;
            state_n  = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = FETCH;
        end else if (!stall) begin
          valid_n = 1'b1;
          ir_n    = buf_ir;
          ipc_n   = buf_pc;
          state_n = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pending_pc_n = redirect_pc;
          if (imem_resp) begin
            pc_n    = redirect_pc;
            state_n = FETCH;
          end
        end else if (imem_resp) begin
          pc_n    = pending_pc;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase

    if (redirect) begin
      valid_n = 1'b0;
      ir_n    = NOP;
    end
  end

  // Memory request and control-ROM fields decode straight from registered state
  assign imem_read    = (state != HOLD);
  assign imem_address = pc;
  assign opcode       = if_id_ir[15:12];
  assign useimm5      = if_id_ir[5];
  assign useJSR       = if_id_ir[11];
  assign shf_D        = if_id_ir[4];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of expected IF/ID contents plus
// point checks on the memory request, covering stall, redirect, reset and wrap cases.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_resp;
  logic [15:0] redirect_pc, imem_rdata;

  logic        imem_read, if_id_valid, useimm5, useJSR, shf_D;
  logic [15:0] imem_address, if_id_ir, if_id_pc;
  logic [3:0]  opcode;

  logic        w_read, w_valid, w_imm5, w_jsr, w_shf;
  logic [15:0] w_addr, w_ir, w_pc;
  logic [3:0]  w_opcode;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .imem_read(imem_read), .imem_address(imem_address), .if_id_valid(if_id_valid),
    .if_id_ir(if_id_ir), .if_id_pc(if_id_pc), .opcode(opcode), .useimm5(useimm5),
    .useJSR(useJSR), .shf_D(shf_D)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .imem_read(w_read), .imem_address(w_addr), .if_id_valid(w_valid),
    .if_id_ir(w_ir), .if_id_pc(w_pc), .opcode(w_opcode), .useimm5(w_imm5),
    .useJSR(w_jsr), .shf_D(w_shf)
  );

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] ea;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare IF/ID against the oldest expected instruction
  task automatic expect_pop(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 16'(if_id_valid), 16'd1);
      chk({tag, "_ir"}, if_id_ir, e.ir);
      chk({tag, "_pc"}, if_id_pc, e.pc);
      chk({tag, "_opcode"}, 16'(opcode), 16'(e.ir[15:12]));
      chk({tag, "_imm5"}, 16'(useimm5), 16'(e.ir[5]));
      chk({tag, "_jsr"}, 16'(useJSR), 16'(e.ir[11]));
      chk({tag, "_shf"}, 16'(shf_D), 16'(e.ir[4]));
    end
  endtask

  // One accepted fetch at the expected address
  task automatic fetch_ok(input string tag, input logic [15:0] data);
    chk({tag, "_addr"}, imem_address, ea);
    chk({tag, "_read"}, 16'(imem_read), 16'd1);
    imem_resp  = 1'b1;
    imem_rdata = data;
    sb.push_back({data, 16'(ea + 16'd2)});
    tick();
    imem_resp  = 1'b0;
    imem_rdata = 16'h0000;
    expect_pop(tag);
    ea = 16'(ea + 16'd2);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_resp = 1'b0; imem_rdata = 16'h0000;
    tick(); tick();
    chk("rst_valid", 16'(if_id_valid), 16'd0);
    chk("rst_ir", if_id_ir, 16'h0000);
    chk("rst_ifpc", if_id_pc, 16'h0000);
    reset = 1'b0;
    chk("post_rst_read", 16'(imem_read), 16'd1);
    chk("post_rst_addr", imem_address, 16'h0000);
    chk("wrap_rst_addr", w_addr, 16'hFFFE);
    ea = 16'h0000;

    // Back-to-back streaming with the wrap instance watching the first fetch
    for (int i = 0; i < 5; i++) begin
      fetch_ok("stream", 16'(16'h1000 + ea));
      if (i == 0) begin
        chk("wrap_ifpc", w_pc, 16'h0000);
        chk("wrap_ir", w_ir, 16'h1000);
        chk("wrap_addr2", w_addr, 16'h0000);
        chk("wrap_valid", 16'(w_valid), 16'd1);
      end
    end

    // Response arrives while decode is stalled with a valid instruction
    chk("stall_addr", imem_address, ea);
    stall = 1'b1; imem_resp = 1'b1; imem_rdata = 16'h5020;
    tick();
    imem_resp = 1'b0; imem_rdata = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      chk("hold_read", 16'(imem_read), 16'd0);
      chk("hold_ir", if_id_ir, 16'h1008);
      chk("hold_valid", 16'(if_id_valid), 16'd1);
      if (i < 2) tick();
    end
    stall = 1'b0;
    sb.push_back({16'h5020, 16'(ea + 16'd2)});
    tick();
    expect_pop("unstall");
    ea = 16'(ea + 16'd2);
    chk("unstall_addr", imem_address, ea);

    // No response, no stall: bubble
    tick();
    chk("bubble_valid", 16'(if_id_valid), 16'd0);
    chk("bubble_ir", if_id_ir, 16'h0000);

    fetch_ok("pre_redir", 16'h100C);
    fetch_ok("pre_redir", 16'h100E);

    // Redirect while the request at 0x0010 is outstanding
    chk("redir_addr0", imem_address, 16'h0010);
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0; redirect_pc = 16'hBEEF;
    chk("drain_addr1", imem_address, 16'h0010);
    chk("drain_read1", 16'(imem_read), 16'd1);
    chk("drain_valid1", 16'(if_id_valid), 16'd0);
    tick();
    chk("drain_addr2", imem_address, 16'h0010);
    chk("drain_valid2", 16'(if_id_valid), 16'd0);
    imem_resp = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    imem_resp = 1'b0;
    chk("drain_valid3", 16'(if_id_valid), 16'd0);
    chk("drain_ir3", if_id_ir, 16'h0000);
    chk("drain_next", imem_address, 16'h0200);

    // Two redirects while draining; the later one wins
    redirect = 1'b1; redirect_pc = 16'h0300;
    tick();
    chk("dbl_addr1", imem_address, 16'h0200);
    redirect_pc = 16'h0400;
    tick();
    chk("dbl_addr2", imem_address, 16'h0200);
    redirect = 1'b0; redirect_pc = 16'h0000;
    imem_resp = 1'b1; imem_rdata = 16'hBAD1;
    tick();
    imem_resp = 1'b0;
    chk("dbl_next", imem_address, 16'h0400);
    chk("dbl_valid", 16'(if_id_valid), 16'd0);
    ea = 16'h0400;

    // Redirect, response and stall together
    fetch_ok("rrs_pre", 16'h1400);
    stall = 1'b1; imem_resp = 1'b1; imem_rdata = 16'h7777;
    redirect = 1'b1; redirect_pc = 16'h0500;
    tick();
    redirect = 1'b0; imem_resp = 1'b0;
    chk("rrs_valid", 16'(if_id_valid), 16'd0);
    chk("rrs_ir", if_id_ir, 16'h0000);
    chk("rrs_read", 16'(imem_read), 16'd1);
    chk("rrs_addr", imem_address, 16'h0500);
    stall = 1'b0;
    ea = 16'h0500;

    // Redirect while holding a buffered instruction
    fetch_ok("hr_pre", 16'h2222);
    stall = 1'b1; imem_resp = 1'b1; imem_rdata = 16'h3333;
    tick();
    imem_resp = 1'b0;
    chk("hr_hold_read", 16'(imem_read), 16'd0);
    redirect = 1'b1; redirect_pc = 16'h0600;
    tick();
    redirect = 1'b0;
    chk("hr_read", 16'(imem_read), 16'd1);
    chk("hr_addr", imem_address, 16'h0600);
    chk("hr_valid", 16'(if_id_valid), 16'd0);
    stall = 1'b0;
    ea = 16'h0600;
    fetch_ok("hr_after", 16'h4A54);

    // Reset during DRAIN; a late response right after is the reset fetch
    redirect = 1'b1; redirect_pc = 16'h0700;
    tick();
    redirect = 1'b0;
    chk("rd_drain_addr", imem_address, 16'h0602);
    reset = 1'b1;
    tick();
    chk("rd_addr", imem_address, 16'h0000);
    chk("rd_valid", 16'(if_id_valid), 16'd0);
    chk("rd_ifpc", if_id_pc, 16'h0000);
    reset = 1'b0;
    ea = 16'h0000;
    fetch_ok("rd_late", 16'h1000);
    chk("rd_next_addr", imem_address, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; every state element updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  high when decode cannot accept a new instruction this cycle (IF/ID enable low).
REQ-005 SHALL have port redirect  input  1  one-cycle pulse for a taken branch, jump, JSR or trap target.
REQ-006 SHALL have port redirect_pc  input  16  the new fetch address, sampled only while redirect is high.
REQ-007 SHALL have port imem_resp  input  1  instruction memory read complete.
REQ-008 SHALL have port imem_rdata  input  16  instruction word, valid only while imem_resp is high.
REQ-009 SHALL have port imem_read  output  1  instruction memory read request.
REQ-010 SHALL have port imem_address  output  16  fetch address.
REQ-011 SHALL have port if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-012 SHALL have port if_id_ir  output  16  IF/ID instruction word.
REQ-013 SHALL have port if_id_pc  output  16  incremented PC (fetch address + 2) of that instruction.
REQ-014 SHALL have ports opcode (4, if_id_ir[15:12]), useimm5 (1, ir[5]), useJSR (1, ir[11]) and shf_D (1, ir[4]), all output and combinational from if_id_ir, feeding the control ROM.

Function
REQ-015 SHALL implement three states: FETCH, HOLD and DRAIN.
REQ-016 In FETCH, imem_read SHALL be 1 and imem_address SHALL equal pc, held stable until imem_resp.
REQ-017 In DRAIN, imem_read SHALL be 1 with the original address held until imem_resp. The response SHALL be discarded, pc SHALL load pending_pc, and the state SHALL go to FETCH.
REQ-018 In HOLD, imem_read SHALL be 0.
REQ-019 On FETCH with imem_resp, and with stall=0 or if_id_valid=0: if_id_ir SHALL load imem_rdata, if_id_pc SHALL load pc+2, if_id_valid SHALL load 1, and pc SHALL load pc+2. The state SHALL stay FETCH, and the next request SHALL be issued in the following cycle.
REQ-020 On FETCH with imem_resp, stall=1 and if_id_valid=1: imem_rdata and pc+2 SHALL be captured in a one-entry buffer, pc SHALL load pc+2, and the state SHALL go to HOLD; the IF/ID register is unchanged.
REQ-021 In HOLD with stall=0, the IF/ID register SHALL load the buffer with valid=1 and the state SHALL go to FETCH.
REQ-022 When stall=0 and nothing loads IF/ID, if_id_valid SHALL become 0 and if_id_ir SHALL become 16'h0000 (BR nzp=000, a NOP).
REQ-023 When stall=1 and nothing loads IF/ID, the IF/ID register SHALL hold its value.
REQ-024 Redirect SHALL take priority over stall and over any response, and SHALL clear the IF/ID register (valid=0, ir=16'h0000) in the same edge.
REQ-025 Redirect in FETCH with imem_resp in the same cycle: the data SHALL be discarded, pc SHALL load redirect_pc, and the state SHALL stay FETCH.
REQ-026 Redirect in FETCH without imem_resp: pending_pc SHALL load redirect_pc and the state SHALL go to DRAIN. An in-flight request is never aborted or re-addressed.
REQ-027 Redirect in DRAIN SHALL overwrite pending_pc (the last redirect wins). If it coincides with imem_resp, pc SHALL load the new redirect_pc.
REQ-028 Redirect in HOLD SHALL discard the buffer, load pc with redirect_pc, and go to FETCH.
REQ-029 PC arithmetic SHALL be 16-bit modulo: 16'hFFFE + 2 = 16'h0000. pc bit 0 is forced to 0 on every load.
REQ-030 Throughput SHALL be one instruction per cycle when imem_resp is asserted every cycle and stall=0.

Reset
REQ-031 On reset the outputs SHALL be: pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_ir=16'h0000, if_id_pc=16'h0000, buffer and pending_pc cleared.
REQ-032 imem_read SHALL be 1 in the first cycle after reset is deasserted, with imem_address=RESET_PC.
REQ-033 Reset mid-request, including in DRAIN or HOLD, SHALL abandon any outstanding response. A late imem_resp in the first post-reset cycle SHALL be accepted as the RESET_PC fetch.

Verification
REQ-034 Streaming: reset, imem_resp=1 every cycle, rdata = 16'h1000 + address, stall=0 -> if_id_pc = 2, 4, 6..., if_id_ir = 16'h1000, 16'h1002..., valid every cycle, opcode = 4'h1.
REQ-035 Stall capture: if_id holds 16'h1000 valid, stall=1 for 3 cycles while resp returns 16'h5020 -> HOLD with imem_read=0 and if_id unchanged. Then stall=0 -> if_id_ir=16'h5020, useimm5=1.
REQ-036 Redirect mid-request: a request at 16'h0010 is outstanding, redirect=1 with redirect_pc=16'h0200, resp arrives 2 cycles later -> imem_address stays 16'h0010 until resp, the data is discarded, the next address is 16'h0200, and valid=0 throughout.
REQ-037 Double redirect in DRAIN: redirects to 16'h0300 then 16'h0400 before resp -> the next fetch is 16'h0400.
REQ-038 Redirect plus resp plus stall in the same cycle -> IF/ID cleared, state FETCH, the next fetch is redirect_pc, and no HOLD is entered.
REQ-039 Wrap: RESET_PC=16'hFFFE, streaming -> the second fetch address is 16'h0000 and if_id_pc of the first instruction is 16'h0000.
